// File: rtl/param_counter_pkg.sv
// ============================================================================
// param_counter_pkg : shared types, constants and helpers for param_counter
// Revision 1.0
// ============================================================================
`default_nettype none

package param_counter_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_t;

  localparam int TC_CNT_W = 16;

  function automatic logic [63:0] clamp_load(input logic [63:0] value,
                                             input logic [63:0] max_val);
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/param_counter_next.sv
// ============================================================================
// param_counter_next : combinational next-count and terminal-count calculator
// Revision 1.0
// ============================================================================
`default_nettype none

module param_counter_next #(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned STEP     = 1,
  parameter int              SATURATE = 0
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             up,
  output logic [WIDTH-1:0] nxt,
  output logic             tc
);

  // One extra bit keeps MAX_VAL+1 and the up-sum representable.
  localparam logic [WIDTH:0] MAX_EXT  = MAX_VAL[WIDTH:0];
  localparam logic [WIDTH:0] STEP_EXT = STEP[WIDTH:0];
  localparam logic [WIDTH:0] MOD_EXT  = MAX_EXT + 1'b1;

  logic [WIDTH:0] cur_ext;
  logic [WIDTH:0] sum;

  always_comb begin
    cur_ext = {1'b0, cur};
    sum     = cur_ext + STEP_EXT;
    nxt     = cur;
    tc      = 1'b0;
    if (up) begin
      if (sum <= MAX_EXT) begin
        nxt = WIDTH'(sum);
      end else begin
        tc = 1'b1;
        if (SATURATE != 0) nxt = WIDTH'(MAX_EXT);
        else               nxt = WIDTH'(sum - MOD_EXT);
      end
    end else begin
      if (cur_ext >= STEP_EXT) begin
        nxt = WIDTH'(cur_ext - STEP_EXT);
      end else begin
        tc = 1'b1;
        if (SATURATE != 0) nxt = '0;
        else               nxt = WIDTH'(cur_ext + (MOD_EXT - STEP_EXT));
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/param_counter.sv
// ============================================================================
// param_counter : parametrised up/down counter with clear, load and tc flag.
// Optional o_tc_cnt statistics output enabled by PARAM_COUNTER_WRAP_CNT_EN.
// Revision 1.0
// ============================================================================
`default_nettype none

module param_counter
  import param_counter_pkg::*;
#(
  parameter int              WIDTH    = 8,
  parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned STEP     = 1,
  parameter longint unsigned INIT_VAL = 0,
  parameter int              SATURATE = 0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_dv,
  input  logic                i_up,
  input  logic                i_clr,
  input  logic                i_load,
  input  logic [WIDTH-1:0]    i_load_val,
  output logic [WIDTH-1:0]    o_data,
  output logic                o_dv,
  output logic                o_tc
`ifdef PARAM_COUNTER_WRAP_CNT_EN
  ,
  output logic [TC_CNT_W-1:0] o_tc_cnt
`endif
);

  dir_t             dir;
  logic [WIDTH-1:0] step_val;
  logic             step_tc;
  logic [WIDTH-1:0] load_clamped;

  assign dir          = dir_t'(i_up);
  assign load_clamped = WIDTH'(clamp_load(64'(i_load_val), 64'(MAX_VAL)));

  param_counter_next #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .STEP     (STEP),
    .SATURATE (SATURATE)
  ) u_next (
    .cur (o_data),
    .up  (dir == DIR_UP),
    .nxt (step_val),
    .tc  (step_tc)
  );

  // Priority: clear > load > step > hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data <= INIT_VAL[WIDTH-1:0];
      o_dv   <= 1'b0;
      o_tc   <= 1'b0;
    end else if (i_clr) begin
      o_data <= '0;
      o_dv   <= 1'b0;
      o_tc   <= 1'b0;
    end else if (i_load) begin
      o_data <= load_clamped;
      o_dv   <= 1'b1;
      o_tc   <= 1'b0;
    end else if (i_dv) begin
      o_data <= step_val;
      o_dv   <= 1'b1;
      o_tc   <= step_tc;
    end else begin
      o_dv   <= 1'b0;
      o_tc   <= 1'b0;
    end
  end

`ifdef PARAM_COUNTER_WRAP_CNT_EN
  // Advances on the same edge that raises o_tc; sticks at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_tc_cnt <= '0;
    end else if (i_clr) begin
      o_tc_cnt <= '0;
    end else if (!i_load && i_dv && step_tc && (o_tc_cnt != {TC_CNT_W{1'b1}})) begin
      o_tc_cnt <= o_tc_cnt + {{(TC_CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

`default_nettype wire
